next_pc_unit: RTL

Parametrised next-PC generator and PC register for the RISC-V core. It succeeds the fixed two-way, 32-bit next-PC mux. It owns the architectural PC and selects among the sequential PC and NUM_EXT redirect targets, with trap override, stall hold, a one-entry pending-redirect buffer and misaligned-target detection. It sits between the ALU/branch logic and instruction memory; pc_o drives the fetch address.

---
 rtl/npc_pkg.sv | 14 +
 rtl/next_pc_unit_redirect_buffer.sv | 47 ++++
 rtl/next_pc_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared constants and helpers for the next-PC unit.
package npc_pkg;

    localparam int                 SEL_SEQ      = 0;
    localparam int                 XLEN_DEF     = 32;
    localparam logic [31:0]        RESET_PC_DEF = 32'h0000_0000;
    localparam int                 PC_INC_DEF   = 4;

    // Select 0 is sequential, 1..num_ext are redirect targets.
    function automatic int sel_width(input int num_ext);
        return $clog2(num_ext + 1);
    endfunction

endpackage

// File: rtl/next_pc_unit_redirect_buffer.sv
// One-entry holder for a redirect that arrived while the PC was stalled.
module redirect_buffer
    import npc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            consume_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] target_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] target_q, target_d;

    // Flush beats capture; a new capture overwrites whatever is held.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/next_pc_unit.sv
// Architectural PC register and next-PC selection with trap override,
// stall hold, a pending-redirect buffer and misaligned-target diversion.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               NUM_EXT  = 2,
    parameter int               SEL_W    = sel_width(NUM_EXT),
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int               PC_INC   = PC_INC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_i,
    input  logic [SEL_W-1:0]        pc_sel_i,
    input  logic [NUM_EXT*XLEN-1:0] ext_target_i,
    input  logic                    trap_i,
    input  logic [XLEN-1:0]         trap_vec_i,
    output logic [XLEN-1:0]         pc_o,
    output logic [XLEN-1:0]         pc_plus_o,
    output logic                    redirect_pending_o,
    output logic                    misalign_o,
    output logic [XLEN-1:0]         bad_addr_o,
    output logic                    sel_err_o
);

    localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(SEL_SEQ);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_EXT);
    localparam logic [XLEN-1:0]  INC      = XLEN'(PC_INC);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic            misalign_q, misalign_d;
    logic            sel_err_q, sel_err_d;

    logic            sel_valid;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] redirect_tgt;
    logic            apply_redirect;
    logic            buf_capture, buf_consume, buf_flush;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;

    assign pc_plus_o = pc_q + INC;
    assign trap_pc   = {trap_vec_i[XLEN-1:2], 2'b00};
    assign sel_valid = (pc_sel_i <= SEL_MAX);

    always_comb begin
        sel_target = '0;
        for (int k = 0; k < NUM_EXT; k++) begin
            if (pc_sel_i == SEL_W'(k + 1)) begin
                sel_target = ext_target_i[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        pc_d           = pc_q;
        bad_addr_d     = bad_addr_q;
        misalign_d     = 1'b0;
        sel_err_d      = 1'b0;
        buf_capture    = 1'b0;
        buf_consume    = 1'b0;
        buf_flush      = 1'b0;
        apply_redirect = 1'b0;
        redirect_tgt   = '0;

        if (trap_i) begin
            pc_d      = trap_pc;
            buf_flush = 1'b1;
        end else if (stall_i) begin
            buf_capture = sel_valid && (pc_sel_i != SEL_ZERO);
        end else if (pend_valid) begin
            apply_redirect = 1'b1;
            redirect_tgt   = pend_target;
            buf_consume    = 1'b1;
        end else if (pc_sel_i == SEL_ZERO) begin
            pc_d = pc_plus_o;
        end else if (sel_valid) begin
            apply_redirect = 1'b1;
            redirect_tgt   = sel_target;
        end else begin
            sel_err_d = 1'b1;
        end

        // Redirects landing off a word boundary go to the trap vector instead.
        if (apply_redirect) begin
            if (redirect_tgt[1:0] != 2'b00) begin
                pc_d       = trap_pc;
                misalign_d = 1'b1;
                bad_addr_d = redirect_tgt;
            end else begin
                pc_d = redirect_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            bad_addr_q <= '0;
            misalign_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            bad_addr_q <= bad_addr_d;
            misalign_q <= misalign_d;
            sel_err_q  <= sel_err_d;
        end
    end

    redirect_buffer #(
        .XLEN (XLEN)
    ) u_redirect_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (buf_capture),
        .target_i  (sel_target),
        .consume_i (buf_consume),
        .flush_i   (buf_flush),
        .valid_o   (pend_valid),
        .target_o  (pend_target)
    );

    assign pc_o               = pc_q;
    assign redirect_pending_o = pend_valid;
    assign misalign_o         = misalign_q;
    assign bad_addr_o         = bad_addr_q;
    assign sel_err_o          = sel_err_q;

endmodule
